// File: rtl/dmem_latency_slave.sv
// dmem_latency_slave
//   Data-memory bus slave for the core's MREQ/WRITE/SIZE/ACKD_n data port.
//   Loads and stores complete after independently configurable latencies.
//   Storage is a big-endian byte-addressed RAM of MEM_BYTES bytes. Two
//   memory-mapped registers are provided: a character-output register and a
//   program-exit register.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   MREQ         request valid; dropping it while waiting aborts the access
//   WRITE        1 = store, 0 = load
//   SIZE         00 word, 01 half, 10/11 byte
//   DAD          byte address
//   DDT_I        store data (byte in [7:0], half in [15:0])
//   DDT_O        load data, zero-extended, held until the next load completes
//   ACKD_n       active-low one-cycle completion strobe
//   stdout_valid one-cycle pulse with a character on stdout_char
//   stdout_char  character written to STDOUT_ADDR
//   exit_flag    sticky, a store to EXIT_ADDR was seen
//   err_flag     sticky, a misaligned or out-of-range access was seen
module dmem_latency_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR = ADDR_WIDTH'(32'hf000_0000),
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR   = ADDR_WIDTH'(32'hff00_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MREQ,
  input  logic                  WRITE,
  input  logic [1:0]            SIZE,
  input  logic [ADDR_WIDTH-1:0] DAD,
  input  logic [31:0]           DDT_I,
  output logic [31:0]           DDT_O,
  output logic                  ACKD_n,
  output logic                  stdout_valid,
  output logic [7:0]            stdout_char,
  output logic                  exit_flag,
  output logic                  err_flag
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t state, next_state;

  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [1:0]            cap_size;
  logic [31:0]           cap_data;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [1:0]            req_size;
  logic [31:0]           req_data;
  logic [3:0]            req_lat;
  logic                  capture;
  logic                  commit;
  logic                  is_stdout;
  logic                  is_exit;
  logic                  in_range;
  logic                  misaligned;
  logic                  mem_we;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           rd_data;

  logic [7:0] mem [MEM_BYTES];

  // A request is accepted from IDLE, or from ACK for back-to-back accesses.
  // When the latency is 1 the access also completes on that same edge, so the
  // request fields come straight from the bus unless we are already waiting.
  always_comb begin
    capture   = MREQ && (state != S_WAIT);
    req_addr  = (state == S_WAIT) ? cap_addr  : DAD;
    req_write = (state == S_WAIT) ? cap_write : WRITE;
    req_size  = (state == S_WAIT) ? cap_size  : SIZE;
    req_data  = (state == S_WAIT) ? cap_data  : DDT_I;
    req_lat   = req_write ? 4'(WR_LATENCY) : 4'(RD_LATENCY);
  end

  // Address decode; misaligned accesses are forced down to the natural boundary.
  always_comb begin
    is_stdout  = (req_addr == STDOUT_ADDR);
    is_exit    = (req_addr == EXIT_ADDR);
    in_range   = (req_addr < ADDR_WIDTH'(MEM_BYTES));
    misaligned = 1'b0;
    idx        = req_addr[IDX_W-1:0];
    if (req_size == 2'b00) begin
      misaligned = (req_addr[1:0] != 2'b00);
      idx[1:0]   = 2'b00;
    end else if (req_size == 2'b01) begin
      misaligned = req_addr[0];
      idx[0]     = 1'b0;
    end
  end

  // Every entry into ACK is a fresh completion, including ACK->ACK at latency 1.
  // The RAM has no reset, so its write enable is gated by rst directly.
  always_comb begin
    commit = (next_state == S_ACK);
    mem_we = commit && rst && req_write && in_range && !is_stdout && !is_exit;
  end

  // Big-endian lanes: the lowest address lands in the most significant lane.
  always_comb begin
    rd_data = '0;
    if (in_range && !is_stdout && !is_exit) begin
      case (req_size)
        2'b00:   rd_data = {mem[idx], mem[idx | IDX_W'(1)],
                            mem[idx | IDX_W'(2)], mem[idx | IDX_W'(3)]};
        2'b01:   rd_data = {16'h0000, mem[idx], mem[idx | IDX_W'(1)]};
        default: rd_data = {24'h000000, mem[idx]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // A withdrawn request while waiting aborts silently; the counter reaching 1
  // on a WAIT edge means this edge is the last one before the ACK cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_ACK: begin
        if (MREQ) next_state = (req_lat <= 4'd1) ? S_ACK : S_WAIT;
        else      next_state = S_IDLE;
      end
      S_WAIT: begin
        if (!MREQ)            next_state = S_IDLE;
        else if (cnt <= 4'd1) next_state = S_ACK;
        else                  next_state = S_WAIT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ACKD_n = (state != S_ACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_size  <= 2'b00;
      cap_data  <= '0;
    end else if (capture) begin
      cnt       <= req_lat - 4'd1;
      cap_addr  <= DAD;
      cap_write <= WRITE;
      cap_size  <= SIZE;
      cap_data  <= DDT_I;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Completion side effects: load data, MMIO outputs and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DDT_O        <= '0;
      stdout_valid <= 1'b0;
      stdout_char  <= '0;
      exit_flag    <= 1'b0;
      err_flag     <= 1'b0;
    end else begin
      stdout_valid <= commit && req_write && is_stdout;
      if (commit && req_write && is_stdout) stdout_char <= req_data[7:0];
      if (commit && !req_write)             DDT_O <= rd_data;
      if (commit && req_write && is_exit)   exit_flag <= 1'b1;
      if (commit && (misaligned || (!in_range && !is_stdout && !is_exit)))
        err_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (req_size)
        2'b00: begin
          mem[idx]               <= req_data[31:24];
          mem[idx | IDX_W'(1)]   <= req_data[23:16];
          mem[idx | IDX_W'(2)]   <= req_data[15:8];
          mem[idx | IDX_W'(3)]   <= req_data[7:0];
        end
        2'b01: begin
          mem[idx]               <= req_data[15:8];
          mem[idx | IDX_W'(1)]   <= req_data[7:0];
        end
        default: mem[idx]        <= req_data[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_latency_slave.sv
// tb_dmem_latency_slave
//   Self-checking bench for dmem_latency_slave. The main instance uses read
//   latency 3 and write latency 2; a second instance with both latencies at 1
//   shares the same inputs and is only inspected in test_latency1.
module tb_dmem_latency_slave;

  localparam logic [31:0] STDOUT_A = 32'hf000_0000;
  localparam logic [31:0] EXIT_A   = 32'hff00_0000;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        MREQ  = 1'b0;
  logic        WRITE = 1'b0;
  logic [1:0]  SIZE  = 2'b00;
  logic [31:0] DAD   = '0;
  logic [31:0] DDT_I = '0;

  logic [31:0] DDT_O;
  logic        ACKD_n, stdout_valid, exit_flag, err_flag;
  logic [7:0]  stdout_char;

  logic [31:0] f_DDT_O;
  logic        f_ACKD_n, f_stdout_valid, f_exit_flag, f_err_flag;
  logic [7:0]  f_stdout_char;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic exp_err  = 1'b0;
  logic exp_exit = 1'b0;

  dmem_latency_slave #(.ADDR_WIDTH(32), .MEM_BYTES(4096), .RD_LATENCY(3), .WR_LATENCY(2),
                       .STDOUT_ADDR(STDOUT_A), .EXIT_ADDR(EXIT_A)) u_dut (
    .clk(clk), .rst(rst), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD),
    .DDT_I(DDT_I), .DDT_O(DDT_O), .ACKD_n(ACKD_n), .stdout_valid(stdout_valid),
    .stdout_char(stdout_char), .exit_flag(exit_flag), .err_flag(err_flag));

  dmem_latency_slave #(.ADDR_WIDTH(32), .MEM_BYTES(4096), .RD_LATENCY(1), .WR_LATENCY(1),
                       .STDOUT_ADDR(STDOUT_A), .EXIT_ADDR(EXIT_A)) u_fast (
    .clk(clk), .rst(rst), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD),
    .DDT_I(DDT_I), .DDT_O(f_DDT_O), .ACKD_n(f_ACKD_n), .stdout_valid(f_stdout_valid),
    .stdout_char(f_stdout_char), .exit_flag(f_exit_flag), .err_flag(f_err_flag));

  always #5 clk = ~clk;

  // One complete access on the main instance: drive, wait for the ACK with a
  // cycle budget, then check latency, load data, stdout and sticky flags.
  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd,
                        input logic sets_err, input logic exp_stdout);
    int lat;
    int n;
    logic [31:0] e;
    lat = wr ? 2 : 3;
    @(negedge clk);
    MREQ = 1'b1; WRITE = wr; SIZE = sz; DAD = addr; DDT_I = data;
    if (!wr) exp_q.push_back(exp_rd);
    if (sets_err) exp_err = 1'b1;
    if (wr && addr == EXIT_A) exp_exit = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ACKD_n !== 1'b0 && n < 20);
    MREQ = 1'b0;
    total++;
    if (n != lat)
      begin bad++; $display("[TB] FAIL latency addr=%h got=%0d want=%0d", addr, n, lat); end
    if (!wr) begin
      e = exp_q.pop_front();
      total++;
      if (DDT_O !== e)
        begin bad++; $display("[TB] FAIL load_data addr=%h got=%h want=%h", addr, DDT_O, e); end
    end
    total++;
    if (stdout_valid !== exp_stdout || (exp_stdout && stdout_char !== data[7:0]))
      begin bad++; $display("[TB] FAIL stdout addr=%h got v=%b c=%h want v=%b c=%h",
                            addr, stdout_valid, stdout_char, exp_stdout, data[7:0]); end
    total++;
    if (err_flag !== exp_err || exit_flag !== exp_exit)
      begin bad++; $display("[TB] FAIL flags addr=%h got err=%b exit=%b want err=%b exit=%b",
                            addr, err_flag, exit_flag, exp_err, exp_exit); end
    @(negedge clk);
    total++;
    if (ACKD_n !== 1'b1 || stdout_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL one_cycle addr=%h got ack_n=%b sv=%b want 1 0",
                            addr, ACKD_n, stdout_valid); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (ACKD_n !== 1'b1 || DDT_O !== 32'h0 || stdout_valid !== 1'b0 || stdout_char !== 8'h00 ||
        exit_flag !== 1'b0 || err_flag !== 1'b0)
      begin bad++; $display("[TB] FAIL reset_state got ack_n=%b d=%h sv=%b c=%h ex=%b er=%b want 1 0 0 0 0 0",
                            ACKD_n, DDT_O, stdout_valid, stdout_char, exit_flag, err_flag); end
    rst = 1'b1;
  endtask

  task automatic test_latency1();
    logic [31:0] e;
    @(negedge clk);
    MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b00; DAD = 32'h10; DDT_I = 32'h1122_3344;
    @(negedge clk);
    total++;
    if (f_ACKD_n !== 1'b0) begin bad++; $display("[TB] FAIL fast_store_ack got=%b want=0", f_ACKD_n); end
    MREQ = 1'b0;
    @(negedge clk);
    total++;
    if (f_ACKD_n !== 1'b1) begin bad++; $display("[TB] FAIL fast_ack_len got=%b want=1", f_ACKD_n); end
    MREQ = 1'b1; WRITE = 1'b0;
    exp_q.push_back(32'h1122_3344);
    @(negedge clk);
    total++;
    if (f_ACKD_n !== 1'b0) begin bad++; $display("[TB] FAIL fast_load_ack got=%b want=0", f_ACKD_n); end
    e = exp_q.pop_front();
    total++;
    if (f_DDT_O !== e) begin bad++; $display("[TB] FAIL fast_load_data got=%h want=%h", f_DDT_O, e); end
    MREQ = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lanes();
    access(1'b1, 2'b00, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    access(1'b1, 2'b00, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    access(1'b1, 2'b10, 32'h13, 32'h0000_00AB, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b01, 32'h12, 32'h0,         32'h0000_33AB, 1'b0, 1'b0);
    access(1'b0, 2'b00, 32'h10, 32'h0,         32'h1122_33AB, 1'b0, 1'b0);
    access(1'b0, 2'b10, 32'h11, 32'h0,         32'h0000_0022, 1'b0, 1'b0);
    access(1'b0, 2'b11, 32'h10, 32'h0,         32'h0000_0011, 1'b0, 1'b0);
    access(1'b1, 2'b00, 32'h20, 32'h0,         32'h0, 1'b0, 1'b0);
    access(1'b1, 2'b01, 32'h22, 32'hFFFF_5566, 32'h0, 1'b0, 1'b0);
    access(1'b1, 2'b01, 32'h20, 32'h1234_BEEF, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b00, 32'h20, 32'h0,         32'hBEEF_5566, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    MREQ = 1'b1; WRITE = 1'b0; SIZE = 2'b00; DAD = 32'h10;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    MREQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ACKD_n !== 1'b1) begin bad++; $display("[TB] FAIL abort_no_ack cycle=%0d got=%b want=1", i, ACKD_n); end
    end
    access(1'b0, 2'b00, 32'h10, 32'h0, 32'h1122_33AB, 1'b0, 1'b0);
  endtask

  task automatic test_mmio();
    access(1'b1, 2'b10, STDOUT_A, 32'hFFFF_FF41, 32'h0, 1'b0, 1'b1);
    access(1'b1, 2'b00, EXIT_A,   32'h0000_0000, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b00, STDOUT_A, 32'h0, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b00, EXIT_A,   32'h0, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b00, 32'h00,   32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    access(1'b1, 2'b00, 32'h04,   32'hCAFE_BABE, 32'h0, 1'b0, 1'b0);
    access(1'b0, 2'b00, 32'h06,   32'h0, 32'hCAFE_BABE, 1'b1, 1'b0);
    access(1'b0, 2'b01, 32'h05,   32'h0, 32'h0000_CAFE, 1'b1, 1'b0);
    access(1'b1, 2'b00, 32'h1000, 32'h9999_9999, 32'h0, 1'b1, 1'b0);
    access(1'b0, 2'b00, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b0);
    access(1'b0, 2'b00, 32'h00,   32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access(1'b1, 2'b00, 32'h0B,   32'h0102_0304, 32'h0, 1'b1, 1'b0);
    access(1'b0, 2'b00, 32'h08,   32'h0, 32'h0102_0304, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] e;
    @(negedge clk);
    MREQ = 1'b1; WRITE = 1'b0; SIZE = 2'b00; DAD = 32'h10;
    exp_q.push_back(32'h1122_33AB);
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (ACKD_n !== 1'b0 && n < 20);
    total++;
    if (n != 3) begin bad++; $display("[TB] FAIL b2b_first_lat got=%0d want=3", n); end
    e = exp_q.pop_front();
    total++;
    if (DDT_O !== e) begin bad++; $display("[TB] FAIL b2b_first_data got=%h want=%h", DDT_O, e); end
    DAD = 32'h04;
    exp_q.push_back(32'hCAFE_BABE);
    n = 0;
    do begin @(negedge clk); n++; end while (ACKD_n !== 1'b0 && n < 20);
    MREQ = 1'b0;
    total++;
    if (n != 3) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=3", n); end
    e = exp_q.pop_front();
    total++;
    if (DDT_O !== e) begin bad++; $display("[TB] FAIL b2b_second_data got=%h want=%h", DDT_O, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MREQ = 1'b1; WRITE = 1'b0; SIZE = 2'b00; DAD = 32'h10;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    exp_err = 1'b0;
    exp_exit = 1'b0;
    total++;
    if (ACKD_n !== 1'b1 || DDT_O !== 32'h0 || err_flag !== exp_err || exit_flag !== exp_exit)
      begin bad++; $display("[TB] FAIL reset_mid got ack_n=%b d=%h er=%b ex=%b want 1 0 0 0",
                            ACKD_n, DDT_O, err_flag, exit_flag); end
    MREQ = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ACKD_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_no_ack cycle=%0d got=%b want=1", i, ACKD_n); end
    end
  endtask

  initial begin
    test_reset();
    test_latency1();
    test_lanes();
    test_abort();
    test_mmio();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
